dq_rd_align: RTL and testbench
==============================

DQ_RD_ALIGN -- requirements
Module: dq_rd_align

Interface
REQ-001 Parameter DW, default 8, DQ lanes per instance (1..16).
REQ-002 Parameter RL, default 6, read latency in SCLK cycles from rd_issue to the first capture cycle (1..28).
REQ-003 Parameter OFS, default 0, beat offset of burst beat 0 within the first capture word (0..3).
REQ-004 Parameter CAL_PAT, default all ones (DW bits), calibration marker beat.
REQ-005 SCLK  input  1  sole clock; all logic on the rising edge.
REQ-006 RSTN  input  1  reset, asynchronous assert, active-low.
REQ-007 rd_issue  input  1  single-cycle pulse marking a BL8 read command.
REQ-008 din  input  4*DW  deserialized DQ, 4 beats per SCLK; beat k = din[k*DW +: DW], beat 0 earliest.
REQ-009 rd_data  output  8*DW  aligned BL8 burst; beat j = rd_data[j*DW +: DW].
REQ-010 rd_valid  output  1  one-cycle qualifier for rd_data.
REQ-011 rd_err  output  1  one-cycle pulse on a rejected rd_issue.

Function
REQ-012 Capture cycle c0 = rd_issue cycle + RL; the 12-beat window is din at c0, c0+1, c0+2, in order.
REQ-013 Output beats 0..7 SHALL be window beats OFS..OFS+7.
REQ-014 rd_valid SHALL assert exactly in cycle c0+3 (latency RL+3); rd_data SHALL be registered and held until the next rd_valid.
REQ-015 Issue tracking SHALL use an RL+3-stage delay line, not a counter, so that overlapping reads are supported.
REQ-016 Reads spaced 2 or more cycles apart SHALL all be delivered, in order, with no beat loss.
REQ-017 An rd_issue within 1 cycle of the previous accepted one SHALL be dropped and rd_err SHALL pulse in the next cycle.
REQ-018 din SHALL be sampled every cycle regardless of rd_issue; a 3-word history register holds the window.
REQ-019 Reads issued simultaneously with reset deassertion SHALL be ignored.

Reset
REQ-020 RSTN low SHALL clear rd_data, rd_valid, rd_err, the delay line, the history and all calibration state immediately.
REQ-021 Reset mid-burst SHALL discard every pending read; no rd_valid SHALL follow reset release for reads issued before it.

Configuration
REQ-022 Macro DQ_RD_ALIGN_CAL_EN compiles in calibration: input cal_en (1), outputs cal_lock (1), cal_lat (5), cal_ofs (2), cal_fail (1).
REQ-023 With the macro, cal_en high arms a search on the next accepted rd_issue: a 5-bit counter starts at 0 and increments each cycle.
REQ-024 During the search, the first cycle in which any din beat equals CAL_PAT SHALL latch cal_lat = counter and cal_ofs = lowest matching beat index, and SHALL set cal_lock.
REQ-025 With the macro, no match by counter value 31 SHALL set cal_fail and clear cal_lock.
REQ-026 With the macro, cal_en low clears cal_lock and cal_fail, and the latched values hold.
REQ-027 With the macro, normal alignment SHALL continue unaffected during a search.
REQ-028 Without the macro, these ports and the associated logic SHALL be absent, and behaviour SHALL be otherwise identical.

Verification
REQ-029 DW=8, RL=6, OFS=0, rd_issue at cycle 10, din=32'h03020100 at cycle 16 and 32'h07060504 at cycle 17 -> rd_valid at cycle 19 with rd_data=64'h0706050403020100.
REQ-030 OFS=2, din beats 00..0B over cycles c0..c0+2 -> rd_data=64'h0908070605040302.
REQ-031 rd_issue at cycles 10, 12, 14 -> three rd_valid pulses at 19, 21, 23, with correct data each; rd_issue at 10 and 11 -> rd_err at 12 and a single rd_valid.
REQ-032 RSTN pulsed low at cycle 17 after rd_issue at 10 -> all outputs 0, and no rd_valid at 19.
REQ-033 With DQ_RD_ALIGN_CAL_EN, cal_en=1, rd_issue at 10, CAL_PAT in beat 3 at cycle 16 -> cal_lock=1, cal_lat=6, cal_ofs=3; no marker present -> cal_fail=1 after 31 cycles.

Source files
------------

// File: rtl/dq_rd_align.sv
// dq_rd_align: read-data alignment for a DDR PHY receive slice.
// Captures a 12-beat window that starts RL SCLK cycles after each BL8 read
// command and returns the 8 beats that begin at beat OFS of that window.
// Compile-time option: define DQ_RD_ALIGN_CAL_EN to add the read-latency /
// beat-offset calibration search (cal_en, cal_lock, cal_lat, cal_ofs, cal_fail).
module dq_rd_align #(
    parameter int              DW      = 8,
    parameter int              RL      = 6,
    parameter int              OFS     = 0,
    parameter logic [DW-1:0]   CAL_PAT = '1
) (
    input  logic               SCLK,
    input  logic               RSTN,
    input  logic               rd_issue,
    input  logic [4*DW-1:0]    din,
`ifdef DQ_RD_ALIGN_CAL_EN
    input  logic               cal_en,
    output logic               cal_lock,
    output logic [4:0]         cal_lat,
    output logic [1:0]         cal_ofs,
    output logic               cal_fail,
`endif
    output logic [8*DW-1:0]    rd_data,
    output logic               rd_valid,
    output logic               rd_err
);

    // Issue delay line: vld_dl[k] is set k+1 cycles after an accepted issue.
    // Together with the rd_valid register this gives RL+3 stages, so several
    // reads can be in flight without any counter.
    logic [RL+1:0]   vld_dl;
    logic            rst_done;
    logic            issue_ok;
    logic            issue_acc;

    // Two most recent din words; together with the live din they form the
    // 3-word capture window (oldest word holds beats 0..3).
    logic [4*DW-1:0] hist_p0;
    logic [4*DW-1:0] hist_p1;
    logic [12*DW-1:0] win;

    // An issue is usable only once a full clock has elapsed after reset
    // release; an issue in the cycle right after an accepted one collides.
    assign issue_ok  = rd_issue & rst_done;
    assign issue_acc = issue_ok & ~vld_dl[0];
    assign win       = {din, hist_p0, hist_p1};

    // Extract the eight burst beats starting at window beat OFS.
    function automatic logic [8*DW-1:0] sel_burst(input logic [12*DW-1:0] w);
        return (8*DW)'(w >> (OFS*DW));
    endfunction

    // Reset-release qualifier: low until the first edge after RSTN rises.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    // Advance the issue delay line and flag rejected back-to-back issues.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_dl <= '0;
            rd_err <= 1'b0;
        end else begin
            vld_dl <= {vld_dl[RL:0], issue_acc};
            rd_err <= issue_ok & vld_dl[0];
        end
    end

    // Sample din every cycle into the window history.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            hist_p0 <= '0;
            hist_p1 <= '0;
        end else begin
            hist_p0 <= din;
            hist_p1 <= hist_p0;
        end
    end

    // Register the aligned burst when the third capture word is on din;
    // rd_data holds until the next delivery.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= vld_dl[RL+1];
            if (vld_dl[RL+1]) begin
                rd_data <= sel_burst(win);
            end
        end
    end

`ifdef DQ_RD_ALIGN_CAL_EN
    logic       cal_srch;
    logic [4:0] cal_cnt;
    logic [4:0] cnt_cur;
    logic       cal_start;
    logic       cal_active;
    logic       pat_hit;
    logic [1:0] pat_idx;

    // A search starts on an accepted issue while cal_en is high and no
    // result is pending; the issue cycle itself counts as latency 0.
    assign cal_start  = cal_en & issue_acc & ~cal_srch & ~cal_lock & ~cal_fail;
    assign cal_active = cal_srch | cal_start;
    assign cnt_cur    = cal_srch ? cal_cnt : 5'd0;

    // Find the lowest din beat equal to the calibration marker.
    always_comb begin
        pat_hit = 1'b0;
        pat_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (din[k*DW +: DW] == CAL_PAT) begin
                pat_hit = 1'b1;
                pat_idx = 2'(k);
            end
        end
    end

    // Calibration search: latch latency/offset on the first marker, give up
    // after counter value 31; dropping cal_en clears status but keeps results.
    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            cal_srch <= 1'b0;
            cal_cnt  <= 5'd0;
            cal_lock <= 1'b0;
            cal_fail <= 1'b0;
            cal_lat  <= 5'd0;
            cal_ofs  <= 2'd0;
        end else if (!cal_en) begin
            cal_srch <= 1'b0;
            cal_cnt  <= 5'd0;
            cal_lock <= 1'b0;
            cal_fail <= 1'b0;
        end else if (cal_active) begin
            if (pat_hit) begin
                cal_lat  <= cnt_cur;
                cal_ofs  <= pat_idx;
                cal_lock <= 1'b1;
                cal_fail <= 1'b0;
                cal_srch <= 1'b0;
            end else if (cnt_cur == 5'd31) begin
                cal_fail <= 1'b1;
                cal_lock <= 1'b0;
                cal_srch <= 1'b0;
            end else begin
                cal_srch <= 1'b1;
                cal_cnt  <= cnt_cur + 5'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dq_rd_align.sv
// Directed bench for dq_rd_align: two instances (OFS=0 and OFS=2) share
// stimulus. Cycle c inputs are applied 1 time unit after edge c-1 and the
// outputs seen in that same window are the cycle-c outputs.
module tb_dq_rd_align;

    localparam int DW = 8;
    localparam int RL = 6;

    logic            SCLK;
    logic            RSTN;
    logic            rd_issue;
    logic [4*DW-1:0] din;
    logic [8*DW-1:0] rd_data_a, rd_data_b;
    logic            rd_valid_a, rd_valid_b;
    logic            rd_err_a, rd_err_b;
`ifdef DQ_RD_ALIGN_CAL_EN
    logic            cal_en;
    logic            cal_lock_a, cal_lock_b;
    logic [4:0]      cal_lat_a, cal_lat_b;
    logic [1:0]      cal_ofs_a, cal_ofs_b;
    logic            cal_fail_a, cal_fail_b;
`endif

    int n_chk;
    int n_err;

    bit iss [0:63];
    bit ev  [0:63];
    bit ee  [0:63];

    dq_rd_align #(.DW(DW), .RL(RL), .OFS(0)) u_dut_a (
        .SCLK     (SCLK),
        .RSTN     (RSTN),
        .rd_issue (rd_issue),
        .din      (din),
`ifdef DQ_RD_ALIGN_CAL_EN
        .cal_en   (cal_en),
        .cal_lock (cal_lock_a),
        .cal_lat  (cal_lat_a),
        .cal_ofs  (cal_ofs_a),
        .cal_fail (cal_fail_a),
`endif
        .rd_data  (rd_data_a),
        .rd_valid (rd_valid_a),
        .rd_err   (rd_err_a)
    );

    dq_rd_align #(.DW(DW), .RL(RL), .OFS(2)) u_dut_b (
        .SCLK     (SCLK),
        .RSTN     (RSTN),
        .rd_issue (rd_issue),
        .din      (din),
`ifdef DQ_RD_ALIGN_CAL_EN
        .cal_en   (cal_en),
        .cal_lock (cal_lock_b),
        .cal_lat  (cal_lat_b),
        .cal_ofs  (cal_ofs_b),
        .cal_fail (cal_fail_b),
`endif
        .rd_data  (rd_data_b),
        .rd_valid (rd_valid_b),
        .rd_err   (rd_err_b)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // Beat k of cycle c carries (4c+k+192) mod 256: cycle 16 gives 00..03.
    function automatic logic [31:0] din_of(input int c);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(c*4 + k + 192);
        return d;
    endfunction

    // Expected burst for capture cycle c0 and offset ofs.
    function automatic logic [63:0] exp_burst(input int c0, input int ofs);
        logic [63:0] e;
        for (int j = 0; j < 8; j++) e[j*8 +: 8] = 8'(c0*4 + ofs + j + 192);
        return e;
    endfunction

    task automatic clr_tab();
        for (int i = 0; i < 64; i++) begin
            iss[i] = 1'b0;
            ev[i]  = 1'b0;
            ee[i]  = 1'b0;
        end
    endtask

    task automatic run_scn(input string nm, input int ncyc, input int rst_c, input bit lit);
        logic [63:0] ed_a, ed_b;
        RSTN     = 1'b0;
        rd_issue = 1'b0;
        din      = '0;
`ifdef DQ_RD_ALIGN_CAL_EN
        cal_en   = 1'b0;
`endif
        repeat (2) @(posedge SCLK);
        #1;
        chk({nm, "_rst_valid"}, 64'(rd_valid_a), 64'd0);
        chk({nm, "_rst_err"},   64'(rd_err_a),   64'd0);
        chk({nm, "_rst_data_a"}, rd_data_a, 64'd0);
        chk({nm, "_rst_data_b"}, rd_data_b, 64'd0);
        ed_a = '0;
        ed_b = '0;
        for (int c = 0; c < ncyc; c++) begin
            RSTN     = (c != rst_c);
            rd_issue = iss[c];
            din      = din_of(c);
            #1;
            if (c == rst_c) begin
                ed_a = '0;
                ed_b = '0;
            end else if (ev[c]) begin
                ed_a = exp_burst(c - 3, 0);
                ed_b = exp_burst(c - 3, 2);
            end
            chk($sformatf("%s_valid@%0d", nm, c), 64'(rd_valid_a), 64'(ev[c]));
            chk($sformatf("%s_err@%0d", nm, c),   64'(rd_err_a),   64'(ee[c]));
            chk($sformatf("%s_data_a@%0d", nm, c), rd_data_a, ed_a);
            chk($sformatf("%s_data_b@%0d", nm, c), rd_data_b, ed_b);
            if (lit && c == 19) begin
                chk("lit_ofs0", rd_data_a, 64'h0706050403020100);
                chk("lit_ofs2", rd_data_b, 64'h0908070605040302);
            end
            @(posedge SCLK);
            #1;
        end
    endtask

`ifdef DQ_RD_ALIGN_CAL_EN
    task automatic run_cal();
        RSTN     = 1'b0;
        rd_issue = 1'b0;
        din      = '0;
        cal_en   = 1'b0;
        repeat (2) @(posedge SCLK);
        #1;
        chk("cal_rst_lock", 64'(cal_lock_a), 64'd0);
        chk("cal_rst_fail", 64'(cal_fail_a), 64'd0);
        chk("cal_rst_lat",  64'(cal_lat_a),  64'd0);
        for (int c = 0; c < 60; c++) begin
            RSTN     = 1'b1;
            cal_en   = (c < 20) || (c >= 22);
            rd_issue = (c == 10) || (c == 25);
            din      = (c == 16) ? 32'hFF00_0000 : 32'h0;
            #1;
            if (c == 16) chk("cal_lock_pre", 64'(cal_lock_a), 64'd0);
            if (c == 17) begin
                chk("cal_lock", 64'(cal_lock_a), 64'd1);
                chk("cal_lat",  64'(cal_lat_a),  64'd6);
                chk("cal_ofs",  64'(cal_ofs_a),  64'd3);
                chk("cal_fail_ok", 64'(cal_fail_a), 64'd0);
            end
            if (c == 19) chk("cal_align_valid", 64'(rd_valid_a), 64'd1);
            if (c == 21) begin
                chk("cal_off_lock", 64'(cal_lock_a), 64'd0);
                chk("cal_off_lat",  64'(cal_lat_a),  64'd6);
                chk("cal_off_ofs",  64'(cal_ofs_a),  64'd3);
            end
            if (c == 56) chk("cal_fail_pre", 64'(cal_fail_a), 64'd0);
            if (c == 57) begin
                chk("cal_fail", 64'(cal_fail_a), 64'd1);
                chk("cal_fail_lock", 64'(cal_lock_a), 64'd0);
            end
            @(posedge SCLK);
            #1;
        end
    endtask
`endif

    initial begin
        n_chk    = 0;
        n_err    = 0;
        RSTN     = 1'b0;
        rd_issue = 1'b0;
        din      = '0;
`ifdef DQ_RD_ALIGN_CAL_EN
        cal_en   = 1'b0;
`endif

        // Single read at 10; the issue at reset release (cycle 0) is ignored.
        clr_tab();
        iss[0] = 1'b1;
        iss[10] = 1'b1;
        ev[19] = 1'b1;
        run_scn("single", 30, -1, 1'b1);

        // Reads two cycles apart, all delivered in order.
        clr_tab();
        iss[10] = 1'b1; iss[12] = 1'b1; iss[14] = 1'b1;
        ev[19]  = 1'b1; ev[21]  = 1'b1; ev[23]  = 1'b1;
        run_scn("burst", 30, -1, 1'b0);

        // Back-to-back issue: second one rejected.
        clr_tab();
        iss[10] = 1'b1; iss[11] = 1'b1;
        ee[12]  = 1'b1;
        ev[19]  = 1'b1;
        run_scn("reject", 30, -1, 1'b0);

        // Reset mid-flight: read at 2 delivered, read at 10 discarded.
        clr_tab();
        iss[2] = 1'b1; iss[10] = 1'b1;
        ev[11] = 1'b1;
        run_scn("reset", 30, 17, 1'b0);

`ifdef DQ_RD_ALIGN_CAL_EN
        run_cal();
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
